neuron_argmax: RTL
==================

Name: neuron_argmax

Overview:
- Downstream stage of the 10-neuron output layer.
- Samples all class scores (signed fixed-point, 8 integer / 18 fractional bits) on a start pulse, then scans them serially, one comparator, one class per cycle.
- Reports the winning class index and its score with a one-cycle done pulse.
- Serial scan keeps comparator count at 1 instead of a 10-input combinational max tree.

Parameters:
- NUM_CLASSES, 10, number of neuron scores compared (must be >= 1).
- SCORE_WIDTH, 26, width of each signed two's-complement score (8.18 format).
- INDEX_WIDTH, 4, width of class index; must satisfy 2**INDEX_WIDTH >= NUM_CLASSES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- IN_SCORES  input  NUM_CLASSES*SCORE_WIDTH  packed scores; class k at [k*SCORE_WIDTH +: SCORE_WIDTH]; sampled only when start is accepted.
- start  input  1  request a classification; accepted only in IDLE.
- busy  output  1  high in SCAN and DONE.
- OUT_CLASS  output  INDEX_WIDTH  index of the maximum score.
- OUT_SCORE  output  SCORE_WIDTH  maximum score value.
- done  output  1  one-cycle pulse when OUT_CLASS/OUT_SCORE become valid.
- valid  output  1  high from done until the next accepted start or reset.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, valid=0, OUT_CLASS=0, OUT_SCORE=0, score bank, counter and best registers cleared. Reset overrides start and any in-progress scan; no done is produced for an aborted scan.
- Registered outputs only; no combinational path from inputs to outputs.
- States:
  - IDLE: busy=0. On start=1: capture all of IN_SCORES into an internal bank, best_score=score[0], best_idx=0, cnt=1. Go to SCAN, or to DONE if NUM_CLASSES==1. Clear valid on the same edge.
  - SCAN: each cycle compare bank[cnt] against best_score as a signed comparison.
    - If bank[cnt] > best_score (strictly greater), update best_score/best_idx.
    - If cnt==NUM_CLASSES-1, register the final best into OUT_CLASS/OUT_SCORE, set done=1 and valid=1, and go to DONE. Otherwise cnt=cnt+1.
  - DONE: done=1 for this single cycle, busy=1. Next edge: done=0 and go to IDLE. Outputs and valid are held.
- Latency: done is high in the cycle following the (NUM_CLASSES-1)th edge after the start-sampling edge. This is 9 edges at default. Throughput: one classification per NUM_CLASSES+1 cycles.
- Ties: the lowest index wins, because updates require strictly greater.
- Arithmetic: pure signed compare, no arithmetic on scores. The most negative value (26'h2000000) is legal. OUT_SCORE is bit-exact to the chosen input.
- start while busy (SCAN or DONE): ignored, no queueing. IN_SCORES changes after capture have no effect.
- start held high continuously: a new classification is accepted on each return to IDLE.
- cnt never exceeds NUM_CLASSES-1; no wrap.

Decomposition:
- Shared package: NUM_CLASSES, SCORE_WIDTH, INDEX_WIDTH, state encoding localparams (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), and a score-slice helper function.
- No sub-module required. The score bank plus a single signed comparator/mux stays inline. Optional sub-module: argmax_compare_cell (signed compare plus select of best score/index), reusable if the layer is later widened.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no start -> busy=0, done=0, valid=0, OUT_CLASS=0, OUT_SCORE=0 indefinitely.
- Distinct scores: score[k]=k*26'h0040000 (k=0..9), start pulse -> done high exactly 9 edges later for one cycle, OUT_CLASS=9, OUT_SCORE=26'h0240000, valid stays 1.
- Negative values and ties: all scores = -1.0 (26'h3FC0000) except score[3]=score[7]=26'h3FF0000 -> OUT_CLASS=3, OUT_SCORE=26'h3FF0000. All ten scores equal 26'h2000000 -> OUT_CLASS=0.
- Busy protection: start at t0, new IN_SCORES and start=1 at t0+4 -> result reflects t0 scores only, single done. Second start accepted only after DONE→IDLE; second done 11 cycles after first start's done edge with start held high.
- Reset mid-scan: start, then rst=1 at t0+5 -> no done pulse, all outputs zero next cycle, state IDLE. A subsequent start completes normally.
- Max at index 0: score[0]=26'h1FFFFFF, others 0 -> OUT_CLASS=0, OUT_SCORE=26'h1FFFFFF, and valid clears on the edge that accepts the next start.

Source files
------------

// File: rtl/neuron_argmax_pkg.sv
// neuron_argmax_pkg
// Shared constants, state encoding and helpers for the output-layer argmax
// stage. Scores are signed two's-complement 8.18 fixed point, packed
// with class k at [k*SCORE_WIDTH +: SCORE_WIDTH].
// No ports (package).
package neuron_argmax_pkg;

   localparam int NUM_CLASSES  = 10;
   localparam int SCORE_WIDTH  = 26;
   localparam int INDEX_WIDTH  = 4;
   localparam int SCORES_WIDTH = NUM_CLASSES * SCORE_WIDTH;

   // Controller states. IDLE waits for start, SCAN walks the captured bank
   // one class per cycle, DONE is the single cycle in which done is high.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Pulls class k out of the packed score bus as a signed value.
   function automatic logic signed [SCORE_WIDTH-1:0] score_slice(
      input logic [SCORES_WIDTH-1:0] scores,
      input int unsigned             k
   );
      score_slice = scores[k*SCORE_WIDTH +: SCORE_WIDTH];
   endfunction

endpackage

// File: rtl/neuron_argmax_if.sv
// neuron_argmax_if
// Bundles the score bus, the start request and the result signals of the
// argmax stage.
//   IN_SCORES  packed class scores, sampled when start is accepted
//   start      request a classification
//   busy       high while scanning and during the done cycle
//   OUT_CLASS  index of the winning class
//   OUT_SCORE  score of the winning class
//   done       one-cycle pulse when the result becomes valid
//   valid      result is valid, held until the next accepted start
// The master modport drives requests; the slave modport is the argmax stage.
interface neuron_argmax_if;
   import neuron_argmax_pkg::*;

   logic [SCORES_WIDTH-1:0] IN_SCORES;
   logic                    start;
   logic                    busy;
   logic [INDEX_WIDTH-1:0]  OUT_CLASS;
   logic [SCORE_WIDTH-1:0]  OUT_SCORE;
   logic                    done;
   logic                    valid;

   modport master (
      output IN_SCORES, start,
      input  busy, OUT_CLASS, OUT_SCORE, done, valid
   );

   modport slave (
      input  IN_SCORES, start,
      output busy, OUT_CLASS, OUT_SCORE, done, valid
   );

endinterface

// File: rtl/neuron_argmax_compare_cell.sv
// neuron_argmax_compare_cell
// One signed compare-and-select step of an argmax. The candidate replaces
// the running best only when strictly greater, so on ties the earlier
// (lower) index is kept.
//   cand_score/cand_idx  score and index being examined
//   best_score/best_idx  running best so far
//   sel_score/sel_idx    best after considering the candidate
module neuron_argmax_compare_cell
   import neuron_argmax_pkg::*;
(
   input  logic signed [SCORE_WIDTH-1:0] cand_score,
   input  logic        [INDEX_WIDTH-1:0] cand_idx,
   input  logic signed [SCORE_WIDTH-1:0] best_score,
   input  logic        [INDEX_WIDTH-1:0] best_idx,
   output logic signed [SCORE_WIDTH-1:0] sel_score,
   output logic        [INDEX_WIDTH-1:0] sel_idx
);

   logic take;

   // Both operands are declared signed, so this is a two's-complement
   // compare; the most negative score orders below everything else.
   assign take      = cand_score > best_score;
   assign sel_score = take ? cand_score : best_score;
   assign sel_idx   = take ? cand_idx   : best_idx;

endmodule

// File: rtl/neuron_argmax.sv
// neuron_argmax
// Downstream stage of the output layer. On an accepted start it captures
// all class scores, then scans them serially through a single comparator,
// one class per cycle, and reports the winning index and score with a
// one-cycle done pulse. The result stays valid until the next start.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts a scan without done
//   bus  neuron_argmax_if slave: IN_SCORES/start in,
//        busy/OUT_CLASS/OUT_SCORE/done/valid out (all registered)
module neuron_argmax
   import neuron_argmax_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   neuron_argmax_if.slave  bus
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(NUM_CLASSES - 1);
   localparam logic [INDEX_WIDTH-1:0] FIRST_CNT = (NUM_CLASSES == 1) ? '0 : INDEX_WIDTH'(1);

   state_t                        state_q;
   state_t                        state_d;
   logic signed [SCORE_WIDTH-1:0] bank_q [NUM_CLASSES];
   logic        [INDEX_WIDTH-1:0] cnt_q;
   logic signed [SCORE_WIDTH-1:0] best_score_q;
   logic        [INDEX_WIDTH-1:0] best_idx_q;
   logic        [INDEX_WIDTH-1:0] out_class_q;
   logic        [SCORE_WIDTH-1:0] out_score_q;
   logic                          done_q;
   logic                          valid_q;
   logic                          accept;
   logic                          scan_last;
   logic signed [SCORE_WIDTH-1:0] sel_score;
   logic        [INDEX_WIDTH-1:0] sel_idx;

   // The one comparator of the design: the bank entry at the scan counter
   // against the running best.
   neuron_argmax_compare_cell u_cmp (
      .cand_score (bank_q[cnt_q]),
      .cand_idx   (cnt_q),
      .best_score (best_score_q),
      .best_idx   (best_idx_q),
      .sel_score  (sel_score),
      .sel_idx    (sel_idx)
   );

   // State register. Reset wins over everything, including a scan that is
   // in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes. start only matters in IDLE, so a
   // request while busy is dropped rather than queued. A single-class
   // layer has nothing to scan and goes straight to DONE.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      scan_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (NUM_CLASSES == 1) begin
                  state_d = DONE;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (cnt_q == LAST_IDX) begin
               scan_last = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath. On accept the whole score bus is frozen into the bank and
   // class 0 seeds the running best. Each SCAN cycle folds one more class
   // in; on the last one the folded result goes straight to the output
   // registers so done and the result appear together. done defaults low
   // so it is a single-cycle pulse; valid drops on the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            bank_q[k] <= '0;
         end
         cnt_q        <= '0;
         best_score_q <= '0;
         best_idx_q   <= '0;
         out_class_q  <= '0;
         out_score_q  <= '0;
         done_q       <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
               bank_q[k] <= score_slice(bus.IN_SCORES, k);
            end
            best_score_q <= score_slice(bus.IN_SCORES, 0);
            best_idx_q   <= '0;
            cnt_q        <= FIRST_CNT;
            if (NUM_CLASSES == 1) begin
               out_class_q <= '0;
               out_score_q <= score_slice(bus.IN_SCORES, 0);
               done_q      <= 1'b1;
               valid_q     <= 1'b1;
            end else begin
               valid_q <= 1'b0;
            end
         end else if (scan_last) begin
            best_score_q <= sel_score;
            best_idx_q   <= sel_idx;
            out_class_q  <= sel_idx;
            out_score_q  <= sel_score;
            done_q       <= 1'b1;
            valid_q      <= 1'b1;
         end else if (state_q == SCAN) begin
            best_score_q <= sel_score;
            best_idx_q   <= sel_idx;
            cnt_q        <= cnt_q + 1'b1;
         end
      end
   end

   // Every output comes straight from a register or from decoded state.
   assign bus.busy      = (state_q != IDLE);
   assign bus.OUT_CLASS = out_class_q;
   assign bus.OUT_SCORE = out_score_q;
   assign bus.done      = done_q;
   assign bus.valid     = valid_q;

endmodule
